// File: rtl/prv32_mdu_pkg.sv
// Shared definitions for the RV32M multiply/divide sequencer.
//  - ALU function codes driven on alu_fn
//  - funct3 encodings of the M-extension operations
//  - sequencer state encoding
//  - helpers deciding operand signedness per operation
package prv32_mdu_pkg;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b1000;

  localparam logic [2:0] MDU_MUL    = 3'b000;
  localparam logic [2:0] MDU_MULH   = 3'b001;
  localparam logic [2:0] MDU_MULHSU = 3'b010;
  localparam logic [2:0] MDU_MULHU  = 3'b011;
  localparam logic [2:0] MDU_DIV    = 3'b100;
  localparam logic [2:0] MDU_DIVU   = 3'b101;
  localparam logic [2:0] MDU_REM    = 3'b110;
  localparam logic [2:0] MDU_REMU   = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PREP = 3'd1,
    ST_ITER = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } mdu_state_e;

  // MUL only produces the low word, which is sign-independent, so it is unsigned here.
  function automatic logic rs1_signed(input logic [2:0] f);
    return (f == MDU_MULH) || (f == MDU_MULHSU) || (f == MDU_DIV) || (f == MDU_REM);
  endfunction

  function automatic logic rs2_signed(input logic [2:0] f);
    return (f == MDU_MULH) || (f == MDU_DIV) || (f == MDU_REM);
  endfunction

endpackage

// File: rtl/prv32_mdu_cneg.sv
// Conditional two's-complement negate.
//  x   in  W  operand
//  neg in  1  1: y = -x, 0: y = x
//  y   out W  result (combinational)
module prv32_mdu_cneg #(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] x,
  input  logic         neg,
  output logic [W-1:0] y
);

  assign y = neg ? (~x + W'(1)) : x;

endmodule

// File: rtl/prv32_mdu_seq.sv
// Multi-cycle RV32M multiply/divide sequencer sharing the core ALU add/sub path.
// Shift-add multiply and restoring divide on operand magnitudes, 32 iterations,
// followed by a sign fix-up step.
//  clk, rst        clock, synchronous active-high reset
//  start, kill     request (sampled in IDLE), pipeline flush
//  funct3          M-extension operation
//  rs1, rs2        operands
//  alu_a/b/fn      shared ALU request (driven only in ITER, else 0 / ADD)
//  alu_r, alu_cf   shared ALU result and carry / no-borrow flag
//  busy, done      status; done is a one-cycle pulse with result valid
//  result          output word, held until the next accepted start
module prv32_mdu_seq
  import prv32_mdu_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            kill,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [3:0]      alu_fn,
  input  logic [XLEN-1:0] alu_r,
  input  logic            alu_cf,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  mdu_state_e state, state_n;

  logic [2:0]      op;
  logic [XLEN-1:0] op_a, op_b;
  logic [XLEN-1:0] addend;   // multiplicand or divisor magnitude
  logic [XLEN-1:0] hi, lo;   // {hi,lo} product, or {R,Q} for divide
  logic            sa, sb;
  logic [CNT_W-1:0] cnt;

  logic            is_div;
  logic            neg_a, neg_b;
  logic [XLEN-1:0] mag_a, mag_b;
  logic            div0, ovf, special;
  logic [XLEN-1:0] special_res;
  logic [2*XLEN-1:0] fix_in, fix_out;
  logic            fix_neg;
  logic [XLEN-1:0] fix_sel;
  logic [XLEN-1:0] rem_shift;
  logic            take;

  assign is_div = op[2];

  // Operand magnitudes for PREP
  assign neg_a = rs1_signed(op) & op_a[XLEN-1];
  assign neg_b = rs2_signed(op) & op_b[XLEN-1];

  prv32_mdu_cneg #(.W(XLEN)) u_mag_a (.x(op_a), .neg(neg_a), .y(mag_a));
  prv32_mdu_cneg #(.W(XLEN)) u_mag_b (.x(op_b), .neg(neg_b), .y(mag_b));

  // Results that skip the iteration entirely
  assign div0    = is_div & (op_b == '0);
  assign ovf     = ((op == MDU_DIV) || (op == MDU_REM)) && (op_a == INT_MIN) && (op_b == '1);
  assign special = div0 | ovf;

  always_comb begin
    special_res = '0;
    if (div0)      special_res = op[1] ? op_a : '1;
    else if (ovf)  special_res = op[1] ? '0 : INT_MIN;
  end

  // Sign fix-up: divide results go through the low half of the 64-bit negator
  always_comb begin
    fix_in  = {hi, lo};
    fix_neg = sa ^ sb;
    if (is_div) begin
      fix_in  = {{XLEN{1'b0}}, (op[1] ? hi : lo)};
      fix_neg = op[1] ? sa : (sa ^ sb);
    end
  end

  prv32_mdu_cneg #(.W(2*XLEN)) u_fix (.x(fix_in), .neg(fix_neg), .y(fix_out));

  assign fix_sel = (op == MDU_MUL || is_div) ? fix_out[XLEN-1:0] : fix_out[2*XLEN-1:XLEN];

  // Restoring divide step; R[msb] is the 33rd bit of the shifted remainder
  assign rem_shift = {hi[XLEN-2:0], lo[XLEN-1]};
  assign take      = hi[XLEN-1] | alu_cf;

  // Next state and shared-ALU request
  always_comb begin
    state_n = state;
    alu_a   = '0;
    alu_b   = '0;
    alu_fn  = ALU_ADD;
    case (state)
      ST_IDLE: if (start) state_n = ST_PREP;
      ST_PREP: state_n = special ? ST_DONE : ST_ITER;
      ST_ITER: begin
        if (cnt == CNT_W'(XLEN-1)) state_n = ST_FIX;
        if (is_div) begin
          alu_a  = rem_shift;
          alu_b  = addend;
          alu_fn = ALU_SUB;
        end else begin
          alu_a  = hi;
          alu_b  = lo[0] ? addend : '0;
        end
      end
      ST_FIX:  state_n = ST_DONE;
      ST_DONE: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
    if (kill) state_n = ST_IDLE;
  end

  // State, status and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      op     <= '0;
      op_a   <= '0;
      op_b   <= '0;
      addend <= '0;
      hi     <= '0;
      lo     <= '0;
      sa     <= 1'b0;
      sb     <= 1'b0;
      cnt    <= '0;
    end else begin
      state <= state_n;
      busy  <= (state_n != ST_IDLE);
      done  <= (state_n == ST_DONE);
      if (state_n == ST_DONE) result <= (state == ST_PREP) ? special_res : fix_sel;
      case (state)
        ST_IDLE: if (state_n == ST_PREP) begin
          op   <= funct3;
          op_a <= rs1;
          op_b <= rs2;
        end
        ST_PREP: begin
          sa  <= neg_a;
          sb  <= neg_b;
          cnt <= '0;
          hi  <= '0;
          if (is_div) begin
            addend <= mag_b;
            lo     <= mag_a;
          end else begin
            addend <= mag_a;
            lo     <= mag_b;
          end
        end
        ST_ITER: begin
          cnt <= cnt + CNT_W'(1);
          if (is_div) begin
            hi <= take ? alu_r : rem_shift;
            lo <= {lo[XLEN-2:0], take};
          end else begin
            hi <= {alu_cf, alu_r[XLEN-1:1]};
            lo <= {alu_r[0], lo[XLEN-1:1]};
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_prv32_mdu_seq.sv
// Directed self-checking bench for prv32_mdu_seq with a behavioural add/sub ALU
// attached to the alu_* ports.
module tb_prv32_mdu_seq;
  import prv32_mdu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        kill = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] rs1 = '0, rs2 = '0;
  logic [31:0] alu_a, alu_b, alu_r;
  logic [3:0]  alu_fn;
  logic        alu_cf;
  logic        busy, done;
  logic [31:0] result;
  logic [32:0] sum;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  prv32_mdu_seq dut (
    .clk(clk), .rst(rst), .start(start), .kill(kill), .funct3(funct3),
    .rs1(rs1), .rs2(rs2), .alu_a(alu_a), .alu_b(alu_b), .alu_fn(alu_fn),
    .alu_r(alu_r), .alu_cf(alu_cf), .busy(busy), .done(done), .result(result)
  );

  // Shared ALU: add gives carry-out, sub gives a>=b unsigned
  always_comb begin
    sum    = {1'b0, alu_a} + {1'b0, alu_b};
    alu_r  = sum[31:0];
    alu_cf = sum[32];
    if (alu_fn == ALU_SUB) begin
      alu_r  = alu_a - alu_b;
      alu_cf = (alu_a >= alu_b);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op; lat counts edges after the accepting edge until done is seen
  task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp,
                        input int exp_lat, input logic [3:0] exp_fn);
    int lat;
    bit fn_ok;
    funct3 = f; rs1 = a; rs2 = b; start = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    lat = -1;
    fn_ok = 1'b1;
    for (int k = 1; k <= 60 && lat < 0; k++) begin
      tick();
      if (k <= 32 && alu_fn !== exp_fn) fn_ok = 1'b0;
      if (done === 1'b1) lat = k;
    end
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_res"}, result, exp);
    if (exp_lat > 1) chk({tag, "_fn"}, 32'(fn_ok), 32'd1);
    tick();
    chk({tag, "_pulse"}, {30'd0, busy, done}, 32'd0);
  endtask

  initial begin
    int ndone;
    int dlat;

    repeat (2) tick();
    chk("rst_busy",   32'(busy), 32'd0);
    chk("rst_done",   32'(done), 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_alu_ab", alu_a | alu_b, 32'd0);
    chk("rst_alu_fn", 32'(alu_fn), 32'(ALU_ADD));
    rst = 1'b0;
    tick();

    run_op("mul",    MDU_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 34, ALU_ADD);
    run_op("mulh",   MDU_MULH,   32'h80000000, 32'h80000000, 32'h40000000, 34, ALU_ADD);
    run_op("mulhu",  MDU_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34, ALU_ADD);
    run_op("mulhsu", MDU_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 34, ALU_ADD);
    run_op("div",    MDU_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 34, ALU_SUB);
    run_op("rem",    MDU_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 34, ALU_SUB);
    run_op("divu",   MDU_DIVU,   32'd100,      32'd7,        32'd14,       34, ALU_SUB);
    run_op("remu",   MDU_REMU,   32'd100,      32'd7,        32'd2,        34, ALU_SUB);
    run_op("divu0",  MDU_DIVU,   32'd5,        32'd0,        32'hFFFFFFFF, 1,  ALU_ADD);
    run_op("rem0",   MDU_REM,    32'h1234,     32'd0,        32'h1234,     1,  ALU_ADD);
    run_op("divovf", MDU_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1,  ALU_ADD);
    run_op("removf", MDU_REM,    32'h80000000, 32'hFFFFFFFF, 32'd0,        1,  ALU_ADD);

    // start while busy is ignored; operand changes after acceptance do not leak in
    funct3 = MDU_DIVU; rs1 = 32'd100; rs2 = 32'd7; start = 1'b1;
    tick();
    start = 1'b0;
    ndone = 0;
    dlat = -1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      start = 1'b0;
      if (k == 4) begin
        start = 1'b1; funct3 = MDU_MUL; rs1 = 32'd3; rs2 = 32'd4;
      end
      if (done === 1'b1) begin
        ndone++;
        if (dlat < 0) dlat = k;
      end
    end
    chk("busy_start_ndone", 32'(ndone), 32'd1);
    chk("busy_start_lat",   32'(dlat),  32'd34);
    chk("busy_start_res",   result,     32'd14);

    // kill mid-operation
    funct3 = MDU_MUL; rs1 = 32'd5; rs2 = 32'd6; start = 1'b1;
    tick();
    start = 1'b0;
    ndone = 0;
    for (int k = 1; k <= 11; k++) begin
      tick();
      kill = (k == 9);
      if (done === 1'b1) ndone++;
      if (k == 10) chk("kill_busy", 32'(busy), 32'd0);
    end
    chk("kill_ndone",  32'(ndone), 32'd0);
    chk("kill_result", result,     32'd14);
    run_op("post_kill", MDU_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34, ALU_ADD);

    // kill beats start in IDLE
    start = 1'b1; kill = 1'b1; funct3 = MDU_MUL; rs1 = 32'd9; rs2 = 32'd9;
    tick();
    start = 1'b0; kill = 1'b0;
    chk("kill_start_busy", 32'(busy), 32'd0);
    tick();
    chk("kill_start_idle", {30'd0, busy, done}, 32'd0);

    // synchronous reset during ITER
    funct3 = MDU_MUL; rs1 = 32'd7; rs2 = 32'hFFFFFFFF; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (10) tick();
    rst = 1'b1;
    tick();
    chk("midrst_busy",   32'(busy), 32'd0);
    chk("midrst_done",   32'(done), 32'd0);
    chk("midrst_result", result,    32'd0);
    chk("midrst_alu_ab", alu_a | alu_b, 32'd0);
    rst = 1'b0;
    tick();
    run_op("after_rst", MDU_MUL, 32'd3, 32'd4, 32'd12, 34, ALU_ADD);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
